// File: rtl/alu_exception_unit_pkg.sv
// Shared definitions for the execute-stage exception unit, the ALU and the decoder.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, exception cause codes, ALU_status bit indices,
// and the prioritised exception-detect helper.
package alu_exception_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_REDIRECT = 3'd2,
    S_HANDLER  = 3'd3,
    S_RETURN   = 3'd4
  } exc_state_t;

  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_OV   = 5'd12;

  // ALU_status bit positions; [2:0] are reserved and always zero
  localparam int STAT_ZERO  = 7;
  localparam int STAT_WIDE  = 6;
  localparam int STAT_OV    = 5;
  localparam int STAT_NEG   = 4;
  localparam int STAT_MISAL = 3;

  typedef struct packed {
    logic       hit;
    logic       addr_err;
    logic [4:0] code;
  } exc_det_t;

  // Address errors outrank overflow, and a load outranks a store.
  function automatic exc_det_t detect_exc(input logic mem_load, input logic mem_store,
                                          input logic ov_trap_en, input logic misal,
                                          input logic ov);
    exc_det_t d;
    d = '0;
    if (mem_load && misal) begin
      d.hit = 1'b1; d.addr_err = 1'b1; d.code = CAUSE_ADEL;
    end else if (mem_store && misal) begin
      d.hit = 1'b1; d.addr_err = 1'b1; d.code = CAUSE_ADES;
    end else if (ov_trap_en && ov) begin
      d.hit = 1'b1; d.code = CAUSE_OV;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_exception_unit_if.sv
// Bundle between execute/fetch and the exception unit.
// Latency: n/a (wires only).
// Backpressure: redirect_valid/redirect_pc are held until redirect_ready.
//
// master: the pipeline side (drives ALU result/status, ERET, redirect_ready).
// slave : the exception unit (drives flags, sticky, flush/stall, redirect, EPC/Cause/BadVAddr, count).
interface alu_exception_unit_if #(
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic             ov_trap_en;
  logic             mem_load;
  logic             mem_store;
  logic [31:0]      ALU_result;
  logic [7:0]       ALU_status;
  logic             eret_valid;
  logic             flags_clr;
  logic             redirect_ready;

  logic [4:0]       flags;
  logic [1:0]       sticky;
  logic             exc_flush;
  logic             ex_stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      epc;
  logic [31:0]      badvaddr;
  logic [4:0]       cause;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output ex_valid, ex_pc, ov_trap_en, mem_load, mem_store, ALU_result, ALU_status,
           eret_valid, flags_clr, redirect_ready,
    input  flags, sticky, exc_flush, ex_stall, redirect_valid, redirect_pc,
           epc, badvaddr, cause, exc_count
  );

  modport slave (
    input  ex_valid, ex_pc, ov_trap_en, mem_load, mem_store, ALU_result, ALU_status,
           eret_valid, flags_clr, redirect_ready,
    output flags, sticky, exc_flush, ex_stall, redirect_valid, redirect_pc,
           epc, badvaddr, cause, exc_count
  );

endinterface

// File: rtl/alu_exception_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Latency: count_o reflects inc_i one clock later.
// Backpressure: none.
//
// Ports: clk, reset (sync, active-high), inc_i (increment request), count_o (value).
module alu_exception_unit_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/alu_exception_unit.sv
// Turns ALU status into flags/sticky/EPC/Cause/BadVAddr and sequences exception entry and ERET.
// Latency: detect at edge N -> flush in cycle N+1 -> redirect from N+2; flags/sticky one clock.
// Backpressure: redirect held stable until redirect_ready; ex_stall high in FLUSH/REDIRECT/RETURN.
//
// Ports: clk, reset (sync, active-high), bus (alu_exception_unit_if.slave) carrying the
// execute-stage op, ERET, flag clear, redirect handshake and all architectural outputs.
module alu_exception_unit
  import alu_exception_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h80000180,
  parameter int          CNT_W      = 16
) (
  input logic                 clk,
  input logic                 reset,
  alu_exception_unit_if.slave bus
);

  exc_state_t  state_q, state_d;
  exc_det_t    det;
  logic        take_exc;
  logic        op_vld;
  logic        stall;
  logic [4:0]  flags_q, flags_d;
  logic [1:0]  sticky_q, sticky_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [4:0]  cause_q, cause_d;
  logic        unused_status;

  assign unused_status = ^bus.ALU_status[2:0];

  assign det = detect_exc(bus.mem_load, bus.mem_store, bus.ov_trap_en,
                          bus.ALU_status[STAT_MISAL], bus.ALU_status[STAT_OV]);

  // Exceptions are only recognised in IDLE; HANDLER masks them.
  assign take_exc = (state_q == S_IDLE) && bus.ex_valid && det.hit;
  // A stalled op is replayed later, so it must not touch flags or sticky now.
  assign op_vld   = bus.ex_valid && !stall;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (take_exc)           state_d = S_FLUSH;
      S_FLUSH:                            state_d = S_REDIRECT;
      S_REDIRECT: if (bus.redirect_ready) state_d = S_HANDLER;
      S_HANDLER:  if (bus.eret_valid)     state_d = S_RETURN;
      S_RETURN:   if (bus.redirect_ready) state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs (pure function of state, so stable while waiting for ready) ----
  always_comb begin
    stall              = 1'b0;
    bus.exc_flush      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = EXC_VECTOR;
    unique case (state_q)
      S_FLUSH: begin
        stall         = 1'b1;
        bus.exc_flush = 1'b1;
      end
      S_REDIRECT: begin
        stall              = 1'b1;
        bus.redirect_valid = 1'b1;
      end
      S_RETURN: begin
        stall              = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = epc_q;
      end
      default: ;
    endcase
  end

  assign bus.ex_stall = stall;

  // ---- architectural state ----
  always_comb begin
    flags_d    = flags_q;
    // clear first, then OR in this cycle's events so a simultaneous set survives
    sticky_d   = bus.flags_clr ? 2'b00 : sticky_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    badvaddr_d = badvaddr_q;
    if (op_vld) begin
      flags_d  = {bus.ALU_status[STAT_ZERO], bus.ALU_status[STAT_NEG], bus.ALU_status[STAT_OV],
                  bus.ALU_status[STAT_WIDE], bus.ALU_status[STAT_MISAL]};
      sticky_d = sticky_d | {bus.ALU_status[STAT_OV], bus.ALU_status[STAT_MISAL]};
    end
    if (take_exc) begin
      epc_d   = bus.ex_pc;
      cause_d = det.code;
      if (det.addr_err) badvaddr_d = bus.ALU_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= '0;
      sticky_q   <= '0;
      epc_q      <= '0;
      cause_q    <= '0;
      badvaddr_q <= '0;
    end else begin
      flags_q    <= flags_d;
      sticky_q   <= sticky_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign bus.flags    = flags_q;
  assign bus.sticky   = sticky_q;
  assign bus.epc      = epc_q;
  assign bus.cause    = cause_q;
  assign bus.badvaddr = badvaddr_q;

  alu_exception_unit_sat_counter #(.W(CNT_W)) u_exc_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (take_exc),
    .count_o (bus.exc_count)
  );

endmodule

// File: tb/tb_alu_exception_unit.sv
// Self-checking bench for alu_exception_unit: scripted random exception episodes,
// a reference model of flags/sticky/EPC/Cause/BadVAddr/count, and a scoreboard of redirects.
// Uses a 4-bit counter so saturation is reachable quickly.
module tb_alu_exception_unit;

  localparam logic [31:0] VEC  = 32'h80000180;
  localparam int          CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [4:0]  cause;
    int          count;
  } redir_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_exception_unit_if #(.CNT_W(CW)) bus ();

  alu_exception_unit #(.EXC_VECTOR(VEC), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // expectations for the cycle currently being driven (combinational outputs)
  logic        chk_en    = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_flush = 1'b0;
  logic        exp_rv    = 1'b0;
  logic [31:0] exp_rpc   = VEC;

  // architectural model (registered outputs as of the last edge)
  logic [4:0]  m_flags  = '0;
  logic [1:0]  m_sticky = '0;
  logic [31:0] m_epc    = '0;
  logic [31:0] m_bad    = '0;
  logic [4:0]  m_cause  = '0;
  int          m_count  = 0;

  redir_t redirect_q[$];
  redir_t mon_e;
  bit     hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ex_stall", 32'(bus.ex_stall), 32'(exp_stall));
      check("exc_flush", 32'(bus.exc_flush), 32'(exp_flush));
      check("redirect_valid", 32'(bus.redirect_valid), 32'(exp_rv));
      if (exp_rv) check("redirect_pc", bus.redirect_pc, exp_rpc);
      check("flags", 32'(bus.flags), 32'(m_flags));
      check("sticky", 32'(bus.sticky), 32'(m_sticky));
      if (bus.redirect_valid && bus.redirect_ready) begin
        if (redirect_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL redirect_unexpected actual=%h required=none", bus.redirect_pc);
        end else begin
          mon_e = redirect_q.pop_front();
          check("xfer_pc", bus.redirect_pc, mon_e.pc);
          check("xfer_epc", bus.epc, mon_e.epc);
          check("xfer_badvaddr", bus.badvaddr, mon_e.bad);
          check("xfer_cause", 32'(bus.cause), 32'(mon_e.cause));
          check("xfer_count", 32'(bus.exc_count), 32'(mon_e.count));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ov_trap_en = 1'b0;
    bus.mem_load = 1'b0; bus.mem_store = 1'b0; bus.ALU_result = '0;
    bus.ALU_status = '0; bus.eret_valid = 1'b0; bus.flags_clr = 1'b0;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    int sel;
    sel = $urandom_range(0, 3);
    bus.ex_valid       = 1'($urandom_range(0, 1));
    bus.ex_pc          = $urandom() & 32'hFFFF_FFFC;
    bus.ov_trap_en     = 1'($urandom_range(0, 1));
    bus.mem_load       = (sel == 1) || (sel == 3);
    bus.mem_store      = (sel == 2) || (sel == 3);
    bus.ALU_result     = $urandom();
    bus.ALU_status     = {5'($urandom()), 3'b000};
    bus.eret_valid     = ($urandom_range(0, 3) == 0);
    bus.flags_clr      = allow_clr && ($urandom_range(0, 3) == 0);
    bus.redirect_ready = 1'($urandom_range(0, 1));
  endtask

  // Drive one cycle with the given expected combinational outputs, then
  // advance the flag/sticky model by the inputs of that cycle.
  task automatic tick(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    logic [4:0] nf;
    logic [1:0] ns;
    logic [7:0] s;
    exp_stall = st; exp_flush = fl; exp_rv = rv; exp_rpc = rpc;
    s  = bus.ALU_status;
    nf = m_flags;
    ns = bus.flags_clr ? 2'b00 : m_sticky;
    if (bus.ex_valid && !st) begin
      nf = {s[7], s[4], s[5], s[6], s[3]};
      ns = ns | {s[5], s[3]};
    end
    @(posedge clk); #1;
    m_flags  = nf;
    m_sticky = ns;
  endtask

  // An op offered while the unit is idle: decide whether it traps.
  task automatic issue(output bit took);
    logic   adel, ades, ovf;
    redir_t e;
    adel = bus.ex_valid && bus.mem_load  && bus.ALU_status[3];
    ades = bus.ex_valid && bus.mem_store && bus.ALU_status[3];
    ovf  = bus.ex_valid && bus.ov_trap_en && bus.ALU_status[5];
    took = adel || ades || ovf;
    if (took) begin
      m_epc   = bus.ex_pc;
      m_cause = adel ? 5'd4 : (ades ? 5'd5 : 5'd12);
      if (adel || ades) m_bad = bus.ALU_result;
      m_count = (m_count >= MAXC) ? MAXC : m_count + 1;
      e = '{pc: VEC, epc: m_epc, bad: m_bad, cause: m_cause, count: m_count};
      redirect_q.push_back(e);
    end
    tick(1'b0, 1'b0, 1'b0, VEC);
  endtask

  task automatic flush_and_redirect(input int w);
    rand_inputs(1'b0);
    tick(1'b1, 1'b1, 1'b0, VEC);
    for (int i = 0; i < w; i++) begin
      rand_inputs(1'b0); bus.redirect_ready = 1'b0;
      tick(1'b1, 1'b0, 1'b1, VEC);
    end
    rand_inputs(1'b0); bus.redirect_ready = 1'b1;
    tick(1'b1, 1'b0, 1'b1, VEC);
  endtask

  task automatic handler_rand(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs(1'b1); bus.eret_valid = 1'b0;
      tick(1'b0, 1'b0, 1'b0, VEC);
    end
  endtask

  task automatic eret_and_return(input int w);
    redir_t e;
    rand_inputs(1'b1); bus.eret_valid = 1'b1;
    e = '{pc: m_epc, epc: m_epc, bad: m_bad, cause: m_cause, count: m_count};
    redirect_q.push_back(e);
    tick(1'b0, 1'b0, 1'b0, VEC);
    for (int i = 0; i < w; i++) begin
      rand_inputs(1'b0); bus.redirect_ready = 1'b0;
      tick(1'b1, 1'b0, 1'b1, m_epc);
    end
    rand_inputs(1'b0); bus.redirect_ready = 1'b1;
    tick(1'b1, 1'b0, 1'b1, m_epc);
  endtask

  task automatic full_exc(input int w1, input int nh, input int w2);
    flush_and_redirect(w1);
    handler_rand(nh);
    eret_and_return(w2);
  endtask

  task automatic check_reset();
    check("rst_flags", 32'(bus.flags), 32'h0);
    check("rst_sticky", 32'(bus.sticky), 32'h0);
    check("rst_exc_flush", 32'(bus.exc_flush), 32'h0);
    check("rst_ex_stall", 32'(bus.ex_stall), 32'h0);
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    check("rst_redirect_pc", bus.redirect_pc, VEC);
    check("rst_epc", bus.epc, 32'h0);
    check("rst_badvaddr", bus.badvaddr, 32'h0);
    check("rst_cause", 32'(bus.cause), 32'h0);
    check("rst_exc_count", 32'(bus.exc_count), 32'h0);
  endtask

  // One reset cycle with noise on the inputs; any pending redirect is dropped.
  task automatic rst_cycle();
    chk_en = 1'b0;
    reset  = 1'b1;
    rand_inputs(1'b1);
    bus.redirect_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_flags = '0; m_sticky = '0; m_epc = '0; m_bad = '0; m_cause = '0; m_count = 0;
    redirect_q.delete();
    check_reset();
    exp_stall = 1'b0; exp_flush = 1'b0; exp_rv = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [7:0] st, input logic ov_en,
                        input logic ld, input logic sto, input logic [31:0] res);
    clear_inputs();
    bus.ex_valid = 1'b1; bus.ex_pc = pc; bus.ALU_status = st; bus.ov_trap_en = ov_en;
    bus.mem_load = ld; bus.mem_store = sto; bus.ALU_result = res; bus.redirect_ready = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clear_inputs();
    @(posedge clk); #1;
    rst_cycle();

    // overflow trap with ready tied high
    set_op(32'h00400010, 8'h20, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(hit);
    check("ovf_cause", 32'(bus.cause), 32'd12);
    check("ovf_epc", bus.epc, 32'h00400010);
    full_exc(0, 1, 0);

    // misaligned load that also overflows: AdEL wins
    set_op(32'h00400020, 8'h28, 1'b1, 1'b1, 1'b0, 32'h00001001);
    issue(hit);
    check("adel_cause", 32'(bus.cause), 32'd4);
    check("adel_badvaddr", bus.badvaddr, 32'h00001001);

    // backpressure on both redirects, then a masked overflow and a clear-vs-set race in HANDLER
    flush_and_redirect(4);
    set_op(32'h00400030, 8'h20, 1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, VEC);
    check("masked_count", 32'(bus.exc_count), 32'(m_count));
    check("masked_sticky_ov", 32'(bus.sticky[1]), 32'h1);
    set_op(32'h00400034, 8'h08, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.flags_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0, VEC);
    check("clr_set_sticky", 32'(bus.sticky), 32'h1);
    handler_rand(1);
    eret_and_return(3);

    // detect and ERET together in IDLE: the exception wins
    set_op(32'h00400040, 8'h20, 1'b1, 1'b0, 1'b0, 32'h0);
    bus.eret_valid = 1'b1;
    issue(hit);
    full_exc(1, 0, 1);

    // reset while REDIRECT waits for ready
    set_op(32'h00400050, 8'h08, 1'b0, 1'b0, 1'b1, 32'h00002002);
    issue(hit);
    rand_inputs(1'b0);
    tick(1'b1, 1'b1, 1'b0, VEC);
    rand_inputs(1'b0); bus.redirect_ready = 1'b0;
    tick(1'b1, 1'b0, 1'b1, VEC);
    rst_cycle();
    set_op(32'h00400060, 8'h08, 1'b0, 1'b0, 1'b1, 32'h00003003);
    issue(hit);
    check("post_rst_ades_cause", 32'(bus.cause), 32'd5);
    full_exc(0, 0, 0);

    // random episodes
    for (int n = 0; n < 300; n++) begin
      rand_inputs(1'b1);
      issue(hit);
      if (hit) full_exc($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // counter saturation
    rst_cycle();
    for (int i = 0; i < MAXC; i++) begin
      set_op(32'h00001000 + 32'(4 * i), 8'h20, 1'b1, 1'b0, 1'b0, 32'h0);
      issue(hit);
      full_exc(0, 0, 0);
    end
    check("count_at_max", 32'(bus.exc_count), 32'(MAXC));
    set_op(32'h00002000, 8'h20, 1'b1, 1'b0, 1'b0, 32'h0);
    issue(hit);
    check("count_saturated", 32'(bus.exc_count), 32'(MAXC));
    full_exc(0, 0, 0);

    clear_inputs();
    tick(1'b0, 1'b0, 1'b0, VEC);
    check("redirects_drained", 32'(redirect_q.size()), 32'h0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
